// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoder constants: format codes, opcodes, NOP word and immediate range limits.
package riscv_enc_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Signed immediate limits; B and J additionally require an even offset.
    localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_IS_MAX =  32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX  =  32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX  =  32'sd1048574;

endpackage

// File: rtl/enc_skid_fifo.sv
// Two-entry shift FIFO; the head always sits in slot0 so the output is a plain register.
module enc_skid_fifo #(
    parameter int unsigned          DATA_W  = 32,
    parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
    input  logic              clk,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              ready_o
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] slot0_q, slot0_d;
    logic [DATA_W-1:0] slot1_q, slot1_d;
    logic              push_ok, pop_ok;

    assign ready_o = (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign data_o  = slot0_q;
    assign push_ok = push_i && ready_o;
    assign pop_ok  = pop_i && valid_o;

    always_comb begin
        count_d = count_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = data_i;
                else                 slot1_d = data_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            // Simultaneous push/pop only happens at occupancy 1: new word becomes the head.
            2'b11: slot0_d = data_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear_i) begin
            count_q <= 2'd0;
            slot0_q <= RST_VAL;
            slot1_q <= RST_VAL;
        end else begin
            count_q <= count_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder with incrementing write address and sticky range error.
// Optional immediate range checking is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
    import riscv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              range_err
);

    localparam int unsigned       DATA_W = 32 + ADDR_W;
    localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [31:0]       instr_c;
    logic              fmt_bad_c;
    logic              imm_bad_c;
    logic              push_c;
    logic              clear_c;

    assign push_c  = in_valid && in_ready;
    assign clear_c = rst || flush;

    // Scatter the immediate into its format-specific bit positions.
    always_comb begin
        instr_c   = NOP_INSTR;
        fmt_bad_c = 1'b0;
        case (fmt)
            FMT_R: instr_c = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: instr_c = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: instr_c = {imm[31:12], rd, opcode};
            FMT_J: instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: begin
                instr_c   = NOP_INSTR;
                fmt_bad_c = 1'b1;
            end
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic signed [31:0] imm_s;
    assign imm_s = $signed(imm);

    always_comb begin
        imm_bad_c = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_bad_c = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
            FMT_B:        imm_bad_c = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm[0];
            FMT_J:        imm_bad_c = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm[0];
            FMT_U:        imm_bad_c = (imm[11:0] != 12'd0);
            default:      imm_bad_c = 1'b0;
        endcase
    end
`else
    assign imm_bad_c = 1'b0;
`endif

    always_comb begin
        addr_d = addr_q;
        err_d  = err_q;
        if (push_c) begin
            addr_d = addr_q + ADDR_W'(4);
            err_d  = err_q | fmt_bad_c | imm_bad_c;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_c) begin
            addr_q <= BASE;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end

    enc_skid_fifo #(
        .DATA_W  (DATA_W),
        .RST_VAL ({32'h0000_0000, BASE})
    ) u_fifo (
        .clk     (clk),
        .clear_i (clear_c),
        .push_i  (push_c),
        .data_i  ({instr_c, addr_q}),
        .pop_i   (out_valid && out_ready),
        .data_o  ({out_instr, out_addr}),
        .valid_o (out_valid),
        .ready_o (in_ready)
    );

    assign range_err = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, backpressure, errors, flush and address wrap.
module tb_instr_encoder;
    import riscv_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [2:0]  fmt;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;

    logic        in_valid, in_ready, out_valid, out_ready, range_err;
    logic [31:0] out_instr, out_addr;

    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_range_err;
    logic [31:0] s_out_instr;
    logic [3:0]  s_out_addr;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_rng;

    always #5 clk = ~clk;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .range_err(range_err)
    );

    instr_encoder #(.BASE_ADDR(32'd12), .ADDR_W(4)) u_small (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_instr(s_out_instr), .out_addr(s_out_addr), .range_err(s_range_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Immediate generator as the core would decode it.
    function automatic logic [31:0] gen_imm(input logic [31:0] w, input logic [2:0] f);
        case (f)
            FMT_S:   gen_imm = {{21{w[31]}}, w[30:25], w[11:7]};
            FMT_B:   gen_imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   gen_imm = {w[31:12], 12'b0};
            FMT_J:   gen_imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            default: gen_imm = {{21{w[31]}}, w[30:20]};
        endcase
    endfunction

    initial begin
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
        exp_rng = 1'b1;
`else
        exp_rng = 1'b0;
`endif
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        s_in_valid = 1'b0; s_out_ready = 1'b1;
        set_fields(FMT_R, OPC_OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);

        do_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        check("rst_err", 32'(range_err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_small_addr", 32'(s_out_addr), 32'd12);

        // addi, sub, sw streamed with out_ready high
        in_valid = 1'b1;
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_instr", out_instr, 32'hFFF0_0093);
        check("addi_addr", out_addr, 32'd0);
        check("addi_err", 32'(range_err), 32'd0);
        set_fields(FMT_R, OPC_OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF);
        step();
        check("sub_instr", out_instr, 32'h4020_81B3);
        check("sub_addr", out_addr, 32'd4);
        set_fields(FMT_S, OPC_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        check("sw_instr", out_instr, 32'h0020_A423);
        check("sw_addr", out_addr, 32'd8);
        check("sw_imm", gen_imm(out_instr, FMT_S), 32'd8);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // back-to-back B, J, U from base address
        do_reset();
        in_valid = 1'b1;
        set_fields(FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        step();
        check("b_instr", out_instr, 32'hFE20_8EE3);
        check("b_addr", out_addr, 32'd0);
        check("b_imm", gen_imm(out_instr, FMT_B), 32'hFFFF_FFFC);
        set_fields(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        check("j_instr", out_instr, 32'h0010_00EF);
        check("j_addr", out_addr, 32'd4);
        check("j_imm", gen_imm(out_instr, FMT_J), 32'd2048);
        set_fields(FMT_U, OPC_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        step();
        check("u_instr", out_instr, 32'h1234_52B7);
        check("u_addr", out_addr, 32'd8);
        check("u_imm", gen_imm(out_instr, FMT_U), 32'h1234_5000);
        in_valid = 1'b0;
        step();
        check("bju_drain", 32'(out_valid), 32'd0);

        // backpressure: three offers, two accepted, head stable
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        check("bp_a_instr", out_instr, 32'h0010_0093);
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        step();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_hold_instr", out_instr, 32'h0010_0093);
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_hold_instr2", out_instr, 32'h0010_0093);
        check("bp_hold_addr", out_addr, 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_b_instr", out_instr, 32'h0020_0093);
        check("bp_b_addr", out_addr, 32'd4);
        check("bp_ready_again", 32'(in_ready), 32'd1);
        step();
        check("bp_c_instr", out_instr, 32'h0030_0093);
        check("bp_c_addr", out_addr, 32'd8);
        in_valid = 1'b0;
        step();
        check("bp_drain", 32'(out_valid), 32'd0);

        // immediate range: -2048 legal, 2048 illegal when checking enabled
        do_reset();
        in_valid = 1'b1;
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        step();
        check("imm_min_instr", out_instr, 32'h8000_0093);
        check("imm_min_err", 32'(range_err), 32'd0);
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        in_valid = 1'b0;
        check("imm_ovf_instr", out_instr, 32'h8000_0093);
        check("imm_ovf_err", 32'(range_err), 32'(exp_rng));
        step(); step();
        check("imm_ovf_sticky", 32'(range_err), 32'(exp_rng));

        // illegal format -> NOP + error, flush clears and restarts address
        do_reset();
        in_valid = 1'b1;
        set_fields(3'd7, OPC_OP, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF);
        step();
        in_valid = 1'b0;
        check("fmt7_instr", out_instr, NOP_INSTR);
        check("fmt7_err", 32'(range_err), 32'd1);
        step();
        check("fmt7_sticky", 32'(range_err), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_err", 32'(range_err), 32'd0);
        check("flush_addr", out_addr, 32'd0);
        in_valid = 1'b1;
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        in_valid = 1'b0;
        check("post_flush_addr", out_addr, 32'd0);
        check("post_flush_instr", out_instr, 32'hFFF0_0093);
        step();

        // flush while full discards both entries; reset wins over a handshake
        out_ready = 1'b0;
        in_valid = 1'b1;
        step(); step();
        check("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fflush_valid", 32'(out_valid), 32'd0);
        check("fflush_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst_drops_input", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("after_rst_addr", out_addr, 32'd0);
        out_ready = 1'b1;
        step();

        // narrow address wraps from 12 to 0
        do_reset();
        s_in_valid = 1'b1;
        set_fields(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        check("wrap_first_addr", 32'(s_out_addr), 32'd12);
        check("wrap_first_instr", s_out_instr, 32'hFFF0_0093);
        step();
        s_in_valid = 1'b0;
        check("wrap_second_addr", 32'(s_out_addr), 32'd0);
        check("wrap_no_err", 32'(s_range_err), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder: the write-side counterpart of the core's immediate generator. It accepts decoded fields (format, opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake and scatters the immediate into the correct bit positions. It emits the packed 32-bit instruction word together with an incrementing instruction-memory byte address. It sits between the test/boot program loader and the instruction memory write port.

## Interface
- `BASE_ADDR`, 32'h0000_0000: first write address after reset or `flush`.
- `ADDR_W`, 32: width of `out_addr`; the address wraps modulo 2^ADDR_W.
- `clk` in 1: the single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `flush` in 1: synchronous clear of the buffer, address and error flag; same effect as `rst`.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: the encoder can accept this cycle.
- `fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `opcode` in 7, `rd` in 5, `rs1` in 5, `rs2` in 5, `funct3` in 3, `funct7` in 7: instruction fields.
- `imm` in 32: sign-extended immediate (byte offset for B/J; upper value with low 12 bits zero for U).
- `out_valid` out 1: encoded word available.
- `out_ready` in 1: downstream accepts the word.
- `out_instr` out 32: encoded instruction.
- `out_addr` out ADDR_W: byte address for `out_instr`.
- `range_err` out 1: sticky flag for an illegal format or an immediate out of range.

## Operation
- An input is accepted when `in_valid && in_ready`. The accepted word is encoded and pushed into a 2-entry output FIFO with the current address; the address counter then increments by 4.
- Field placement by format:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Fields a format does not use are ignored.
- An illegal `fmt` (6 or 7) emits NOP 32'h0000_0013 at the normal address and sets `range_err`.
- Output pops on `out_valid && out_ready`. The FIFO head drives `out_instr`/`out_addr`, and these hold stable while `out_valid && !out_ready`.
- `in_ready = (occupancy < 2)`. A push and a pop in the same cycle leave occupancy unchanged; the pop takes the head and the push appends.
- `range_err` clears only on `rst` or `flush`.
- Address wrap: at 2^ADDR_W − 4, the next address is 0, with no flag.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `range_err`=0, `in_ready`=1, occupancy=0, address counter=BASE_ADDR.
- Latency: an input accepted at edge N appears on `out_valid`/`out_instr` in the cycle after edge N. There is no combinational path from input to output.
- Throughput: one word per cycle while `out_ready` is held high.
- `in_ready` depends only on registered occupancy, never on `out_ready`.
- `rst` or `flush` asserted together with a handshake: reset wins, the input is dropped, and no pop is counted.
- `flush` while full: both entries are discarded, and the next accepted word gets BASE_ADDR.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined: at acceptance, the immediate is checked against its format's range, and a violation sets `range_err`. The word is still emitted, built from the truncated bits.
  - I/S: −2048..2047.
  - B: −4096..4094, and bit0 must be 0.
  - J: −2^20..2^20−2, and bit0 must be 0.
  - U: imm[11:0]=0.
- Undefined: no immediate check. `range_err` is set only by an illegal `fmt`.

## Structure
- Shared package `riscv_enc_pkg` holds:
  - format code constants `FMT_R`..`FMT_J`;
  - the RV32I opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - `NOP_INSTR`;
  - the range limits.
- One sub-module, `enc_skid_fifo`: a 2-entry FIFO of {instr, addr} with occupancy, push/pop and clear. The encode and range logic stay in the top level.

## Test plan
- After reset, drive I-type addi x1,x0,−1 (opcode 0010011, rd 1, imm 32'hFFFF_FFFF) → 32'hFFF0_0093 at address 0 one cycle later; `range_err`=0.
- Back-to-back B (rs1 1, rs2 2, funct3 0, imm −4), J (rd 1, imm 2048), U lui (rd 5, imm 32'h1234_5000), all with `out_ready`=1 → 32'hFE20_8EE3, 32'h0010_00EF, 32'h1234_52B7 at addresses 0, 4, 8. Feeding each word through the core's immediate generator returns the original imm.
- Hold `out_ready`=0 and offer 3 inputs → two are accepted, then `in_ready`=0. `out_instr` stays stable. Release `out_ready` → the words appear in order, with no loss or duplication.
- With the macro defined, an I-type imm 2048 → `range_err` rises one cycle after acceptance and stays set. With the macro undefined → `range_err` stays 0.
- `fmt`=7 → NOP 32'h0000_0013 is emitted and `range_err`=1. A following `flush` clears `range_err`, and the next word is at BASE_ADDR.
- `ADDR_W`=4 with BASE_ADDR 12 → two words at addresses 12, then 0 (wrap).
